regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writeback requesters (ALU, load unit, link/jal).
//  Each requester gets a one-entry holding buffer behind a valid/ready handshake.
//  A round-robin arbiter drains held entries one per cycle into registered RegWrite/RDaddr/RDdata outputs.
//  Sits between the execute/memory stages and the register file; also owns the write-to-$0 error flag.
// PARAMETERS
//  NREQ  3   number of writeback requesters (2..8)
//  AW    5   register address width
//  DW    32  register data width
// PORTS
//  clk_i          in   1         clock, rising edge
//  rst_i          in   1         asynchronous reset, active-low
//  stall_i        in   1         1 = issue no write this cycle; held entries are kept
//  req_valid_i    in   NREQ      requester i presents a write
//  req_ready_o    out  NREQ      requester i may hand over a write this cycle
//  req_addr_i     in   NREQ*AW   destination register; slice i = [i*AW +: AW]
//  req_data_i     in   NREQ*DW   write data; slice i = [i*DW +: DW]
//  req_zok_i      in   NREQ      1 = write to $0 is legal (jr/sll/nop forms); suppresses error
//  RegWrite_o     out  1         register-file write enable (registered)
//  RDaddr_o       out  AW        register-file write address (registered)
//  RDdata_o       out  DW        register-file write data (registered)
//  gnt_o          out  NREQ      one-hot: requester whose entry drives the outputs this cycle (registered)
//  Error_Zero_o   out  1         one-cycle pulse: illegal write to $0 was dropped (registered)
//  busy_o         out  1         OR of all holding-buffer valid bits (combinational)
// BEHAVIOUR
//  Reset (rst_i=0, async): all hold_v cleared; rr_ptr=0; RegWrite_o=0, RDaddr_o=0, RDdata_o=0,
//   gnt_o=0, Error_Zero_o=0. Reset mid-operation discards every held and in-flight write.
//  Holding buffer per requester: hold_v, hold_addr, hold_data, hold_zok.
//  Accept: valid_i[i] & ready_o[i] at a rising edge loads buffer i.
//  ready_o[i] = ~hold_v[i] | win[i]. Depends only on state and stall_i, never on req_valid_i.
//  Same-edge drain and refill of buffer i is allowed: full throughput of 1 write/cycle per requester
//   when that requester is the only one active.
//  Arbitration (combinational, each cycle): when stall_i=0, win is the first i with hold_v[i]=1,
//   searching from rr_ptr upward with wrap NREQ-1 -> 0. win=0 when stall_i=1 or no entry is held.
//  At the edge with a winner w:
//   hold_v[w] clears (unless refilled that edge); rr_ptr <= (w+1) mod NREQ; gnt_o <= onehot(w).
//   If hold_addr[w]!=0: RegWrite_o<=1, RDaddr_o<=hold_addr[w], RDdata_o<=hold_data[w], Error_Zero_o<=0.
//   If hold_addr[w]==0: RegWrite_o<=0, RDaddr_o<=0, RDdata_o<=0; Error_Zero_o <= ~hold_zok[w].
//   The entry is consumed either way.
//  At an edge with no winner: RegWrite_o<=0, gnt_o<=0, Error_Zero_o<=0; rr_ptr unchanged;
//   RDaddr_o/RDdata_o hold their last value.
//  Latency: accepted at edge k -> earliest RegWrite_o=1 after edge k+1 -> register file writes at edge k+2.
//  Ordering: writes from the same requester leave in acceptance order. Across requesters, order is
//   grant order; equal addresses from two requesters resolve last-granted-wins. Hazard control upstream
//   must not rely on any other ordering.
//  stall_i=1: no grant and no ready from win; empty buffers still accept. Stall never drops data.
//  Fairness: a held entry is granted within NREQ non-stalled cycles.
// TESTING
//  1 Reset: rst_i=0 with buffers full -> all outputs 0 asynchronously; busy_o=0; after release,
//    req 0 addr=5 data=0x11 -> RegWrite_o=1, RDaddr_o=5 one cycle after accept.
//  2 All 3 requesters valid every cycle (addr 1/2/3) -> gnt_o sequence 001,010,100,001...;
//    RegWrite_o=1 every cycle; no requester waits >3 cycles.
//  3 Single requester 1 streaming addr 7..10 back-to-back -> ready_o[1] stays 1; RDaddr_o 7,8,9,10
//    on consecutive cycles.
//  4 Req 2 addr=0 data=0xFF zok=0 -> RegWrite_o=0, Error_Zero_o=1 for exactly one cycle;
//    same with zok=1 -> Error_Zero_o stays 0.
//  5 stall_i=1 for 4 cycles with buffers 0 and 2 full -> RegWrite_o=0, ready_o=3'b010;
//    release -> entries 0 then 2 issued in order, data intact.
//  6 rst_i pulsed low while buffer 1 is held and RegWrite_o=1 -> output drops immediately;
//    held write is never issued after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. Each requester has a one-entry holding buffer.
// A round-robin arbiter drains one held entry per cycle into registered write-port outputs.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic [NREQ-1:0]    req_valid_i,
   output logic [NREQ-1:0]    req_ready_o,
   input  logic [NREQ*AW-1:0] req_addr_i,
   input  logic [NREQ*DW-1:0] req_data_i,
   input  logic [NREQ-1:0]    req_zok_i,
   output logic               RegWrite_o,
   output logic [AW-1:0]      RDaddr_o,
   output logic [DW-1:0]      RDdata_o,
   output logic [NREQ-1:0]    gnt_o,
   output logic               Error_Zero_o,
   output logic               busy_o
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] hold_v_q, hold_v_d, hold_zok_q, load;
   logic [AW-1:0]   hold_addr_q [NREQ];
   logic [DW-1:0]   hold_data_q [NREQ];
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

   logic [NREQ-1:0] win;
   logic            win_any;
   logic [PW-1:0]   win_idx;
   logic [PW:0]     scan_idx;

   logic            regwrite_q, regwrite_d;
   logic [AW-1:0]   rdaddr_q, rdaddr_d;
   logic [DW-1:0]   rddata_q, rddata_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            err_q, err_d;

   // Scan from rr_ptr upward with wrap; first held entry wins unless stalled.
   always_comb begin
      win      = '0;
      win_any  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      if (!stall_i) begin
         for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NREQ)) scan_idx = scan_idx - (PW+1)'(NREQ);
            if (!win_any && hold_v_q[scan_idx[PW-1:0]]) begin
               win_any = 1'b1;
               win_idx = scan_idx[PW-1:0];
            end
         end
      end
      if (win_any) win[win_idx] = 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_buf
         // A winning entry frees its slot at the same edge, allowing drain and refill together.
         assign req_ready_o[gi] = ~hold_v_q[gi] | win[gi];
         assign load[gi]        = req_valid_i[gi] & req_ready_o[gi];
         assign hold_v_d[gi]    = load[gi] | (hold_v_q[gi] & ~win[gi]);
      end
   endgenerate

   always_comb begin
      regwrite_d = 1'b0;
      gnt_d      = '0;
      err_d      = 1'b0;
      rdaddr_d   = rdaddr_q;
      rddata_d   = rddata_q;
      rr_ptr_d   = rr_ptr_q;
      if (win_any) begin
         gnt_d    = win;
         rr_ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
         if (hold_addr_q[win_idx] != '0) begin
            regwrite_d = 1'b1;
            rdaddr_d   = hold_addr_q[win_idx];
            rddata_d   = hold_data_q[win_idx];
         end else begin
            // Writes to $0 are consumed without a write; flag only the illegal forms.
            rdaddr_d = '0;
            rddata_d = '0;
            err_d    = ~hold_zok_q[win_idx];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hold_v_q   <= '0;
         hold_zok_q <= '0;
         rr_ptr_q   <= '0;
         regwrite_q <= 1'b0;
         rdaddr_q   <= '0;
         rddata_q   <= '0;
         gnt_q      <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            hold_addr_q[i] <= '0;
            hold_data_q[i] <= '0;
         end
      end else begin
         hold_v_q   <= hold_v_d;
         rr_ptr_q   <= rr_ptr_d;
         regwrite_q <= regwrite_d;
         rdaddr_q   <= rdaddr_d;
         rddata_q   <= rddata_d;
         gnt_q      <= gnt_d;
         err_q      <= err_d;
         for (int i = 0; i < NREQ; i++) begin
            if (load[i]) begin
               hold_addr_q[i] <= req_addr_i[i*AW +: AW];
               hold_data_q[i] <= req_data_i[i*DW +: DW];
               hold_zok_q[i]  <= req_zok_i[i];
            end
         end
      end
   end

   assign RegWrite_o   = regwrite_q;
   assign RDaddr_o     = rdaddr_q;
   assign RDdata_o     = rddata_q;
   assign gnt_o        = gnt_q;
   assign Error_Zero_o = err_q;
   assign busy_o       = |hold_v_q;
endmodule
